// File: rtl/uart_tx_module.sv
// -----------------------------------------------------------------------------
// uart_tx_module
//
// UART transmitter. Bytes enter a small FIFO over a valid/ready handshake and
// are sent on Tx as: start bit (0), 8 data bits LSB first, an optional parity
// bit, and one stop bit (1). Every bit lasts 16 strobes of clk_16bd. Parity
// enable/odd is written over the shared 4-bit register bus and is captured
// per frame when the byte is loaded, so a mid-frame write only affects later
// frames.
//
// Ports:
//   clk       in   system clock (only clock)
//   rst       in   synchronous active-high reset
//   clk_16bd  in   one-cycle strobe at 16x baud
//   address   in   [3:0] register-bus address
//   data      in   [3:0] register-bus write data (bit0 parity en, bit1 odd)
//   valid     in   register-bus write strobe
//   ack       out  one-cycle acknowledge for a write to CFG_ADDR
//   tx_data   in   [7:0] byte offered for transmission
//   tx_valid  in   tx_data is offered
//   tx_ready  out  FIFO has room (count < FIFO_DEPTH)
//   busy      out  a frame is on the line or the FIFO is non-empty
//   Tx        out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_module #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CFG_ADDR   = 4'h6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_16bd,
    input  logic [3:0] address,
    input  logic [3:0] data,
    input  logic       valid,
    output logic       ack,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       Tx
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity is the XOR of the data bits; odd mode inverts it.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // FIFO storage and pointers
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Frame engine
    logic [2:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;

    // Configuration and registered outputs
    logic [1:0] cfg_q, cfg_d;
    logic       ack_q, ack_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;

    logic       push_s;
    logic       pop_s;
    logic       fifo_room_s;
    logic       fifo_nempty_s;
    logic       tick_end_s;
    logic [3:0] tick_adv_s;
    logic [7:0] head_s;
    logic       unused_cfg_bits_s;

    assign fifo_room_s       = (count_q < CNT_W'(FIFO_DEPTH));
    assign fifo_nempty_s     = (count_q != {CNT_W{1'b0}});
    assign push_s            = tx_valid && fifo_room_s;
    assign head_s            = mem_q[rd_ptr_q];
    assign tick_end_s        = clk_16bd && (tick_q == 4'd15);
    assign tick_adv_s        = clk_16bd ? (tick_q + 4'd1) : tick_q;
    assign unused_cfg_bits_s = ^data[3:2];

    assign tx_ready = fifo_room_s;
    assign ack      = ack_q;
    assign busy     = busy_q;
    assign Tx       = tx_q;

    // Frame FSM: state, tick counter, bit index and per-frame load of byte + parity config.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Strobes are ignored here; the tick counter restarts on load.
                if (fifo_nempty_s) begin
                    pop_s     = 1'b1;
                    shift_d   = head_s;
                    par_en_d  = cfg_q[0];
                    par_bit_d = parity_bit(head_s, cfg_q[1]);
                    tick_d    = 4'd0;
                    idx_d     = 3'd0;
                    state_d   = ST_START;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                tick_d = tick_adv_s;
                if (tick_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                tick_d = tick_adv_s;
                if (tick_end_s) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                tick_d = tick_adv_s;
                if (tick_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                tick_d = tick_adv_s;
                if (tick_end_s) begin
                    // Queued byte goes straight into the next start bit, no idle bit.
                    if (fifo_nempty_s) begin
                        pop_s     = 1'b1;
                        shift_d   = head_s;
                        par_en_d  = cfg_q[0];
                        par_bit_d = parity_bit(head_s, cfg_q[1]);
                        tick_d    = 4'd0;
                        idx_d     = 3'd0;
                        state_d   = ST_START;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = 4'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Line level for the state currently held; registered, so Tx trails the state by one cycle.
    always_comb begin
        case (state_q)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[idx_q];
            ST_PARITY: tx_d = par_bit_q;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    // FIFO pointer/count update; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Register-bus write decode and busy derived from next-state values.
    always_comb begin
        ack_d = valid && (address == CFG_ADDR);
        if (ack_d) begin
            cfg_d = data[1:0];
        end else begin
            cfg_d = cfg_q;
        end
        busy_d = (state_d != ST_IDLE) || (count_d != {CNT_W{1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= 4'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            cfg_q     <= 2'b00;
            ack_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cfg_q     <= cfg_d;
            ack_q     <= ack_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    // FIFO data array; contents need no reset because the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_module.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_module
//
// Self-checking bench for uart_tx_module. A frame monitor compares the line
// against frames derived from the pushed bytes (start, data LSB first,
// optional parity, stop; 16 strobes per bit, sampled at the 8th strobe).
// -----------------------------------------------------------------------------
module tb_uart_tx_module;

    localparam int         CLK_P = 10;
    localparam logic [3:0] CFG   = 4'h6;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_16bd;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       Tx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        time        t;
    } ent_t;

    ent_t       exp_q[$];
    int         par_log[$];
    logic [1:0] cfg_model = 2'b00;
    bit         stb_en = 1'b0;
    int         frames_done = 0;
    int         sc = 0;
    bit         in_frame = 1'b0;

    uart_tx_module #(.FIFO_DEPTH(4), .CFG_ADDR(CFG)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_16bd (clk_16bd),
        .address  (address),
        .data     (data),
        .valid    (valid),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .Tx       (Tx)
    );

    always #(CLK_P/2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe generator: single-cycle pulses, 2..3 cycles apart, when enabled.
    initial begin
        int gap;
        gap = 0;
        clk_16bd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stb_en && gap == 0) begin
                clk_16bd = 1'b1;
                gap = $urandom_range(2, 1);
            end else begin
                clk_16bd = 1'b0;
                if (gap > 0) gap--;
            end
        end
    end

    // Frame monitor / reference model.
    logic [10:0] bits_v;
    int          nbits;
    logic [1:0]  cc;
    logic [7:0]  cur;
    bit          stb;
    bit          b2b;
    time         t_edge;
    time         end_t;

    initial begin
        nbits = 10;
        b2b   = 1'b0;
        end_t = 0;
        forever begin
            @(posedge clk);
            stb    = clk_16bd;
            t_edge = $time;
            @(negedge clk);
            if (rst === 1'b1) begin
                in_frame = 1'b0;
                b2b      = 1'b0;
            end else if (in_frame) begin
                if (stb) begin
                    sc++;
                    if (sc % 16 == 8) begin
                        check($sformatf("bit%0d_of_%02h", sc / 16, cur), 32'(Tx), 32'(bits_v[sc / 16]));
                        if (cc[0] && sc / 16 == 9) par_log.push_back(int'(Tx));
                    end
                    if (sc == 16 * nbits) begin
                        check("stop_end", 32'(Tx), 32'd1);
                        in_frame = 1'b0;
                        frames_done++;
                        end_t = t_edge;
                        b2b = (exp_q.size() > 0) && (exp_q[0].t < t_edge);
                        if (exp_q.size() == 0) check("busy_fall", 32'(busy), 32'd0);
                    end
                end
            end else if (Tx === 1'b0) begin
                check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (b2b) check("b2b_gap", 32'(t_edge - end_t), 32'(CLK_P));
                b2b = 1'b0;
                if (exp_q.size() > 0) begin
                    cur = exp_q[0].b;
                    void'(exp_q.pop_front());
                end else begin
                    cur = 8'h00;
                end
                cc = cfg_model;
                bits_v = 11'h7FF;
                bits_v[0] = 1'b0;
                for (int i = 0; i < 8; i++) bits_v[i + 1] = cur[i];
                if (cc[0]) begin
                    bits_v[9] = (($countones(cur) % 2) == 1) ^ cc[1];
                    nbits = 11;
                end else begin
                    nbits = 10;
                end
                in_frame = 1'b1;
                sc = stb ? 1 : 0;
            end
        end
    end

    task automatic push(input logic [7:0] b, output bit ok);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        ok = tx_ready;
        @(posedge clk);
        if (ok) exp_q.push_back('{b, $time});
        #1 tx_valid = 1'b0;
    endtask

    task automatic push_retry(input logic [7:0] b);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 3000) begin
            push(b, ok);
            n++;
        end
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d, input int hold);
        @(negedge clk);
        address = a;
        data    = d;
        valid   = 1'b1;
        check("ack_before", 32'(ack), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == hold - 1) valid = 1'b0;
            check("ack_pulse", 32'(ack), (a == CFG) ? 32'd1 : 32'd0);
        end
        valid = 1'b0;
        if (a == CFG) cfg_model = d[1:0];
        @(negedge clk);
        check("ack_drop", 32'(ack), 32'd0);
    endtask

    task automatic wait_frames(input int target, input int bound);
        int n;
        n = 0;
        while (frames_done < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("frame_wait", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic wait_sc(input int target, input int bound);
        int n;
        n = 0;
        while (!(in_frame && sc >= target) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("sc_wait", 32'(in_frame && sc >= target), 32'd1);
    endtask

    initial begin
        bit ok;
        bit okv[6];
        int f0;
        int n;
        rst      = 1'b1;
        valid    = 1'b0;
        address  = 4'h0;
        data     = 4'h0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_Tx", 32'(Tx), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        stb_en = 1'b1;
        repeat (2) @(negedge clk);

        // No parity, 0x55, with push-to-start latency
        push(8'h55, ok);
        check("push55_ok", 32'(ok), 32'd1);
        @(negedge clk);
        check("busy_after_push", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_pop_edge", 32'(Tx), 32'd1);
        @(negedge clk);
        check("lat_start_edge", 32'(Tx), 32'd0);
        wait_frames(1, 2000);

        // Parity even then odd on 0x07
        cfg_write(CFG, 4'b0001, 1);
        push_retry(8'h07);
        wait_frames(2, 2000);
        check("par_even_07", 32'(par_log[par_log.size() - 1]), 32'd1);
        cfg_write(CFG, 4'b0011, 2);
        push_retry(8'h07);
        wait_frames(3, 2000);
        check("par_odd_07", 32'(par_log[par_log.size() - 1]), 32'd0);

        // FIFO full with strobes held off
        cfg_write(CFG, 4'b0000, 1);
        stb_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom), ok);
            okv[i] = ok;
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("full_push%0d", i), 32'(okv[i]), (i < 5) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("full_tx_ready", 32'(tx_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        stb_en = 1'b1;
        wait_frames(8, 10000);

        // Config change mid-frame
        cfg_write(CFG, 4'b0001, 1);
        push_retry(8'h01);
        wait_sc(40, 2000);
        cfg_write(CFG, 4'b0011, 1);
        push_retry(8'h01);
        wait_frames(10, 4000);
        n = par_log.size();
        check("mid_cfg_par_cur", 32'(par_log[n - 2]), 32'd1);
        check("mid_cfg_par_next", 32'(par_log[n - 1]), 32'd0);

        // Reset mid-frame with bytes queued
        push_retry(8'h3C);
        push_retry(8'hC3);
        push_retry(8'h5A);
        wait_sc(40, 2000);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        cfg_model = 2'b00;
        @(negedge clk);
        check("rstmid_Tx", 32'(Tx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        f0 = frames_done;
        repeat (600) @(negedge clk);
        check("rstmid_no_frames", 32'(frames_done), 32'(f0));
        check("rstmid_line_idle", 32'(Tx), 32'd1);
        push_retry(8'h07);
        wait_frames(f0 + 1, 2000);

        // Wrong address leaves config alone
        cfg_write(4'h2, 4'b0011, 1);
        push_retry(8'hA5);
        wait_frames(f0 + 2, 2000);

        // Randomised traffic with occasional config changes while idle
        f0 = frames_done;
        n = 0;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                int w;
                w = 0;
                while (busy !== 1'b0 && w < 4000) begin
                    @(negedge clk);
                    w++;
                end
                check("rand_idle_wait", 32'(busy), 32'd0);
                cfg_write(CFG, 4'($urandom_range(3, 0)), 1);
            end
            for (int j = 0; j < int'($urandom_range(3, 1)); j++) begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                push_retry(8'($urandom));
                n++;
            end
        end
        wait_frames(f0 + n, 20000);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
